// File: rtl/load_run_ctrl.sv
// Purpose : loads IMEM, RF and DMEM from a word stream, holds core reset, then runs the core until halt or timeout.
// Latency : an accepted load word appears on wr_en/wr_addr/wr_data exactly one cycle after acceptance.
// Backpress: in_ready is high only in the load states; in_valid low stalls loading with no state or address change.
module load_run_ctrl #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int RF_DEPTH   = 32,
  parameter int DMEM_DEPTH = 64,
  parameter int RST_CYCLES = 1,
  parameter int RUN_CYCLES = 6,
  localparam int MAX_DEPTH = (IMEM_DEPTH > RF_DEPTH)
                             ? ((IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH)
                             : ((RF_DEPTH > DMEM_DEPTH) ? RF_DEPTH : DMEM_DEPTH),
  localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_rst_n,
  input  logic              halt,
  output logic [31:0]       cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  // Elaboration-time guards against degenerate parameter choices.
  if (IMEM_DEPTH < 1) begin : g_bad_imem
    $error("load_run_ctrl: IMEM_DEPTH must be >= 1");
  end
  if (RF_DEPTH < 1) begin : g_bad_rf
    $error("load_run_ctrl: RF_DEPTH must be >= 1");
  end
  if (DMEM_DEPTH < 1) begin : g_bad_dmem
    $error("load_run_ctrl: DMEM_DEPTH must be >= 1");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("load_run_ctrl: RST_CYCLES must be >= 1");
  end
  if (RUN_CYCLES < 1) begin : g_bad_run
    $error("load_run_ctrl: RUN_CYCLES must be >= 1");
  end

  // Last word address of each region; hitting it moves on to the next region.
  localparam logic [AW-1:0] IMEM_LAST = AW'(IMEM_DEPTH - 1);
  localparam logic [AW-1:0] RF_LAST   = AW'(RF_DEPTH - 1);
  localparam logic [AW-1:0] DMEM_LAST = AW'(DMEM_DEPTH - 1);

  // Terminal counts for the reset hold and the run window.
  localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

  // One-hot write strobes per target memory.
  localparam logic [2:0] WE_IMEM = 3'b001;
  localparam logic [2:0] WE_RF   = 3'b010;
  localparam logic [2:0] WE_DMEM = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_R = 3'd2,
    LOAD_D = 3'd3,
    HOLD   = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [31:0]         hold_cnt_q, hold_cnt_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic                timeout_q, timeout_d;
  logic [2:0]          wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic                loading;
  logic                accept;
  logic                region_last;
  logic [2:0]          region_we;

  // Decode which region is being loaded and whether the current word closes it.
  always_comb begin
    loading     = 1'b0;
    region_last = 1'b0;
    region_we   = 3'b000;
    case (state_q)
      LOAD_I: begin
        loading     = 1'b1;
        region_last = (addr_q == IMEM_LAST);
        region_we   = WE_IMEM;
      end
      LOAD_R: begin
        loading     = 1'b1;
        region_last = (addr_q == RF_LAST);
        region_we   = WE_RF;
      end
      LOAD_D: begin
        loading     = 1'b1;
        region_last = (addr_q == DMEM_LAST);
        region_we   = WE_DMEM;
      end
      default: begin
        loading     = 1'b0;
        region_last = 1'b0;
        region_we   = 3'b000;
      end
    endcase
  end

  assign accept = in_valid & loading;

  // Register each accepted word as a one-cycle write; strobes drop otherwise while address/data hold.
  always_comb begin
    wr_en_d   = 3'b000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_en_d   = region_we;
      wr_addr_d = addr_q;
      wr_data_d = in_data;
    end
  end

  // Next-state logic plus the load address, hold and run counters it steers.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD_I;
          addr_d      = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
        end
      end
      LOAD_I, LOAD_R, LOAD_D: begin
        if (accept) begin
          if (region_last) begin
            addr_d = '0;
            case (state_q)
              LOAD_I:  state_d = LOAD_R;
              LOAD_R:  state_d = LOAD_D;
              default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
              end
            endcase
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      RUN: begin
        // The exiting cycle still counts as a run cycle; halt wins over timeout.
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (halt) begin
          state_d   = DONE;
          timeout_d = 1'b0;
        end else if (cycle_cnt_q == RUN_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
      wr_en_q     <= 3'b000;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign in_ready   = loading;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst_n = (state_q == RUN);
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign timeout    = timeout_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_load_run_ctrl.sv
// Purpose : directed self-checking bench for load_run_ctrl with small memories.
// Latency : outputs are sampled 1 ns after each rising edge.
// Backpress: in_valid stalls and ignored start/halt are driven explicitly.
module tb_load_run_ctrl;

  localparam int DATA_W = 32;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [2:0]        wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              core_rst_n;
  logic              halt;
  logic [31:0]       cycle_cnt;
  logic              busy;
  logic              done;
  logic              timeout;

  int n_cmp = 0;
  int n_err = 0;

  load_run_ctrl #(
    .DATA_W    (DATA_W),
    .IMEM_DEPTH(4),
    .RF_DEPTH  (2),
    .DMEM_DEPTH(2),
    .RST_CYCLES(1),
    .RUN_CYCLES(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .core_rst_n(core_rst_n),
    .halt      (halt),
    .cycle_cnt (cycle_cnt),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected target strobe / address for word index 0..7 of a full load (IMEM 4, RF 2, DMEM 2).
  function automatic logic [2:0] exp_en(input int i);
    if (i < 4)      return 3'b001;
    else if (i < 6) return 3'b010;
    else            return 3'b100;
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    if (i < 4)      return 32'(i);
    else if (i < 6) return 32'(i - 4);
    else            return 32'(i - 6);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'd0);
    chk({tag, ".wr_en"},      32'(wr_en),      32'd0);
    chk({tag, ".wr_addr"},    32'(wr_addr),    32'd0);
    chk({tag, ".wr_data"},    wr_data,         32'd0);
    chk({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, ".cycle_cnt"},  cycle_cnt,       32'd0);
    chk({tag, ".busy"},       32'(busy),       32'd0);
    chk({tag, ".done"},       32'(done),       32'd0);
    chk({tag, ".timeout"},    32'(timeout),    32'd0);
  endtask

  // Present one word with in_valid high and check the write that follows it.
  task automatic load(input string tag, input logic [31:0] data, input logic [2:0] en, input logic [31:0] addr);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    chk({tag, ".wr_en"},   32'(wr_en),   32'(en));
    chk({tag, ".wr_addr"}, 32'(wr_addr), addr);
    chk({tag, ".wr_data"}, wr_data,      data);
  endtask

  // Load words first..last of the 8-word image, data = base + index.
  task automatic load_seq(input string tag, input logic [31:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      load($sformatf("%s.w%0d", tag, i), base + 32'(i), exp_en(i), exp_addr(i));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; halt = 1'b0;
    tick();
    tick();
    chk_reset("por");
    rst = 1'b0;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);

    // Full sequence ending in timeout.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s1.in_ready", 32'(in_ready), 32'd1);
    chk("s1.busy",     32'(busy),     32'd1);
    load_seq("s1", 32'd1, 0, 7);
    in_valid = 1'b0;
    chk("s1.hold.in_ready",   32'(in_ready),   32'd0);
    chk("s1.hold.core_rst_n", 32'(core_rst_n), 32'd0);
    chk("s1.hold.busy",       32'(busy),       32'd1);
    tick();
    chk("s1.run.core_rst_n", 32'(core_rst_n), 32'd1);
    chk("s1.run.wr_en",      32'(wr_en),      32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("s1.run%0d.cycle_cnt", k), cycle_cnt, 32'(k));
      chk($sformatf("s1.run%0d.done", k),      32'(done), 32'd0);
    end
    tick();
    chk("s1.end.done",       32'(done),       32'd1);
    chk("s1.end.timeout",    32'(timeout),    32'd1);
    chk("s1.end.cycle_cnt",  cycle_cnt,       32'd6);
    chk("s1.end.busy",       32'(busy),       32'd0);
    chk("s1.end.core_rst_n", 32'(core_rst_n), 32'd0);
    tick();
    chk("s1.idle.cycle_cnt", cycle_cnt, 32'd6);

    // Restart from DONE, stalled load with ignored start, halt in HOLD ignored, halt on 3rd RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s2.done",      32'(done),     32'd0);
    chk("s2.timeout",   32'(timeout),  32'd0);
    chk("s2.cycle_cnt", cycle_cnt,     32'd0);
    chk("s2.in_ready",  32'(in_ready), 32'd1);
    load("s2.a", 32'h0000_00A1, 3'b001, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("s2.stall1.wr_en", 32'(wr_en), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s2.stall2.wr_en",    32'(wr_en),    32'd0);
    chk("s2.stall2.in_ready", 32'(in_ready), 32'd1);
    load("s2.b", 32'h0000_00A2, 3'b001, 32'd1);
    load_seq("s2", 32'd0, 2, 7);
    in_valid = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("s2.run.core_rst_n", 32'(core_rst_n), 32'd1);
    chk("s2.run.done",       32'(done),       32'd0);
    tick();
    chk("s2.run1.cycle_cnt", cycle_cnt, 32'd1);
    tick();
    chk("s2.run2.cycle_cnt", cycle_cnt, 32'd2);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("s2.end.done",       32'(done),       32'd1);
    chk("s2.end.cycle_cnt",  cycle_cnt,       32'd3);
    chk("s2.end.timeout",    32'(timeout),    32'd0);
    chk("s2.end.core_rst_n", 32'(core_rst_n), 32'd0);

    // Halt on the final (6th) RUN cycle beats timeout.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("s3", 32'h10, 0, 7);
    in_valid = 1'b0;
    tick();
    chk("s3.run.core_rst_n", 32'(core_rst_n), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("s3.run%0d.cycle_cnt", k), cycle_cnt, 32'(k));
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("s3.end.cycle_cnt", cycle_cnt,    32'd6);
    chk("s3.end.timeout",   32'(timeout), 32'd0);
    chk("s3.end.done",      32'(done),    32'd1);

    // Reset after the 5th accepted word, with start/in_valid/halt also asserted.
    start = 1'b1;
    tick();
    start = 1'b0;
    load_seq("s4", 32'h20, 0, 4);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; halt = 1'b1;
    tick();
    chk_reset("rst_load");
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; halt = 1'b0;
    tick();
    chk("s4.idle.in_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    load("s4.reload", 32'h0000_0055, 3'b001, 32'd0);
    load_seq("s4b", 32'h30, 1, 7);
    in_valid = 1'b0;
    tick();
    chk("s4.run.core_rst_n", 32'(core_rst_n), 32'd1);
    tick();
    tick();
    chk("s4.run2.cycle_cnt", cycle_cnt, 32'd2);
    rst = 1'b1; halt = 1'b1;
    tick();
    chk_reset("rst_run");
    rst = 1'b0; halt = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    load("s5.reload", 32'h0000_0099, 3'b001, 32'd0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
